// File: rtl/irq_controller.sv
// Eight-source interrupt controller with per-source mask and edge/level mode.
// One request is in flight at a time; the lowest-index source has priority.
module irq_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] src,
  input  logic       cfgWe,
  input  logic [1:0] cfgAddr,
  input  logic [7:0] cfgData,
  output logic [7:0] cfgRdata,
  output logic       irIrq,
  output logic [3:0] irData,
  input  logic       irResponse
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] edg_q, edg_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] prev_q;
  logic       irq_q, irq_d;
  logic [2:0] idx_q, idx_d;

  logic [7:0] rise;
  logic [7:0] req;
  logic [7:0] clr;
  logic [7:0] pend_view;
  logic [2:0] win;
  logic       any;
  logic       ack;

  assign rise = src & ~prev_q;
  assign req  = mask_q & ((edg_q & pend_q) | (~edg_q & src));
  assign any  = |req;
  assign ack  = (state_q == REQ) && irResponse;

  assign pend_view = (edg_q & pend_q) | (~edg_q & src);

  always_comb begin
    win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) win = i[2:0];
    end
  end

  always_comb begin
    mask_d = mask_q;
    edg_d  = edg_q;
    if (cfgWe && cfgAddr == A_MASK) mask_d = cfgData;
    if (cfgWe && cfgAddr == A_EDGE) edg_d  = cfgData;
  end

  // Set has priority over clear; level-mode bits never latch.
  always_comb begin
    clr = 8'd0;
    if (cfgWe && cfgAddr == A_PEND) clr = cfgData;
    if (ack) clr[idx_q] = 1'b1;
    pend_d = edg_q & ((pend_q & ~clr) | rise);
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          idx_d   = win;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irResponse) begin
          irq_d   = 1'b0;
          idx_d   = 3'd0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        irq_d = 1'b0;
        idx_d = 3'd0;
        if (!irResponse) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        idx_d   = 3'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 8'd0;
      edg_q   <= 8'd0;
      pend_q  <= 8'd0;
      prev_q  <= 8'd0;
      irq_q   <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      edg_q   <= edg_d;
      pend_q  <= pend_d;
      prev_q  <= src;
      irq_q   <= irq_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    cfgRdata = 8'd0;
    unique case (cfgAddr)
      A_MASK:  cfgRdata = mask_q;
      A_EDGE:  cfgRdata = edg_q;
      A_PEND:  cfgRdata = pend_view;
      A_STAT:  cfgRdata = {3'b000, state_q,
                           (state_q == REQ) ? idx_q : 3'd0};
      default: cfgRdata = 8'd0;
    endcase
  end

  assign irIrq  = irq_q;
  assign irData = {1'b0, idx_q};

endmodule
